// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control unit for the 16-bit accumulator machine.
// Owns PC, IR, MAR, MBR and AC; sequences a synchronous 1-cycle-read memory and a
// combinational ALU.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   run                 permits a new fetch (sampled only in FETCH)
//   mem_addr/wdata/we   memory request; wdata is always AC
//   mem_rdata           memory read data, valid the cycle after the address
//   alu_opcode          ALU operation select; operands are AC and MBR
//   alu_result          combinational ALU result
//   pc_out, ac_out      architectural PC and AC
//   instr_done          one-cycle pulse when an instruction retires
//   halted, illegal     sticky status
`timescale 1ns/1ps
module instr_sequencer #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_operand1,
  output logic [15:0] alu_operand2,
  input  logic [15:0] alu_result,
  output logic [11:0] pc_out,
  output logic [15:0] ac_out,
  output logic        instr_done,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] OpHalt    = 4'h0;
  localparam logic [3:0] OpLoad    = 4'h1;
  localparam logic [3:0] OpStore   = 4'h2;
  localparam logic [3:0] OpAdd     = 4'h3;
  localparam logic [3:0] OpSub     = 4'h4;
  localparam logic [3:0] OpAnd     = 4'h5;
  localparam logic [3:0] OpOr      = 4'h6;
  localparam logic [3:0] OpXor     = 4'h7;
  localparam logic [3:0] OpJump    = 4'h8;
  localparam logic [3:0] OpSkipz   = 4'h9;
  localparam logic [3:0] OpSkipneg = 4'hA;
  localparam logic [3:0] OpShl     = 4'hB;
  localparam logic [3:0] OpShr     = 4'hC;
  localparam logic [3:0] OpClear   = 4'hD;

  typedef enum logic [2:0] {
    StFetch,
    StIrLoad,
    StDecode,
    StRdAddr,
    StMbrLoad,
    StExec,
    StStoreWr,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [11:0] mar_q, mar_d;
  logic [15:0] mbr_q, mbr_d;
  logic [15:0] ac_q, ac_d;
  logic        illegal_q, illegal_d;
  logic [3:0]  opcode;

  assign opcode = ir_q[15:12];

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      mar_q     <= '0;
      mbr_q     <= '0;
      ac_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mbr_q     <= mbr_d;
      ac_q      <= ac_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (run) state_d = StIrLoad;
      StIrLoad:  state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpAdd, OpSub, OpAnd, OpOr, OpXor: state_d = StRdAddr;
          OpStore:                                  state_d = StStoreWr;
          OpHalt, 4'hE, 4'hF:                       state_d = StHalt;
          default:                                  state_d = StExec;
        endcase
      end
      StRdAddr:  state_d = StMbrLoad;
      StMbrLoad: state_d = StExec;
      StExec:    state_d = StFetch;
      StStoreWr: state_d = StFetch;
      StHalt:    state_d = StHalt;
    endcase
  end

  // Datapath register updates
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mbr_d     = mbr_q;
    ac_d      = ac_q;
    illegal_d = illegal_q;
    case (state_q)
      StIrLoad: begin
        ir_d = mem_rdata;
        pc_d = pc_q + 12'd1;
      end
      StDecode: begin
        mar_d = ir_q[11:0];
        if (opcode == 4'hE || opcode == 4'hF) illegal_d = 1'b1;
      end
      StMbrLoad: mbr_d = mem_rdata;
      StExec: begin
        case (opcode)
          OpLoad:                                           ac_d = mbr_q;
          OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr:   ac_d = alu_result;
          OpJump:                                           pc_d = ir_q[11:0];
          OpSkipz:   if (ac_q == 16'h0000) pc_d = pc_q + 12'd1;
          OpSkipneg: if (ac_q[15])         pc_d = pc_q + 12'd1;
          OpClear:                                          ac_d = '0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Outputs, decoded from state and registers only
  always_comb begin
    mem_addr   = {4'b0000, pc_q};
    mem_we     = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      StRdAddr:  mem_addr = {4'b0000, mar_q};
      StStoreWr: begin
        mem_addr   = {4'b0000, mar_q};
        mem_we     = 1'b1;
        instr_done = 1'b1;
      end
      StExec:    instr_done = 1'b1;
      default: ;
    endcase

    case (opcode)
      OpAdd:   alu_opcode = 4'b0000;
      OpSub:   alu_opcode = 4'b0001;
      OpAnd:   alu_opcode = 4'b1000;
      OpOr:    alu_opcode = 4'b1001;
      OpXor:   alu_opcode = 4'b1010;
      OpShl:   alu_opcode = 4'b0100;
      OpShr:   alu_opcode = 4'b0101;
      default: alu_opcode = 4'b0000;
    endcase
  end

  assign mem_wdata    = ac_q;
  assign alu_operand1 = ac_q;
  assign alu_operand2 = mbr_q;
  assign pc_out       = pc_q;
  assign ac_out       = ac_q;
  assign halted       = (state_q == StHalt);
  assign illegal      = illegal_q;

endmodule
